ls166: RTL

LS166 -- requirements
Module: ls166

---
 rtl/ls166_pkg.sv | 9 +
 rtl/ls166_cell.sv | 26 ++
 rtl/ls166.sv | 43 ++++
 3 files changed

// File: rtl/ls166_pkg.sv
// Shared constants for the ls166 parallel-in/serial-out shift register.
package ls166_pkg;
  localparam int LS166_WIDTH = 8;

  localparam logic MODE_LOAD  = 1'b0;
  localparam logic MODE_SHIFT = 1'b1;

  typedef logic [LS166_WIDTH-1:0] ls166_word_t;
endpackage

// File: rtl/ls166_cell.sv
// One ls166 stage: parallel/upstream 2:1 mux into a flop with async clear and hold.
module ls166_cell
  import ls166_pkg::*;
(
  input  logic clk,
  input  logic _clr,
  input  logic hold,
  input  logic sh_ld,
  input  logic par,
  input  logic up,
  output logic q
);

  logic nxt;

  assign nxt = (sh_ld == MODE_SHIFT) ? up : par;

  // Inhibit is a hold enable on the flop, never a gated clock.
  always_ff @(posedge clk or negedge _clr) begin
    if (!_clr)
      q <= 1'b0;
    else if (!hold)
      q <= nxt;
  end

endmodule

// File: rtl/ls166.sv
// Behavioural 74LS166 8-bit PISO shift register (s[7]=A ... s[0]=H).
// Optional macro LS166_TAP_EN exports all stage states on q.
module ls166
  import ls166_pkg::*;
(
  input  logic                   clk,
  input  logic                   _clr,
  input  logic                   clk_inh,
  input  logic                   sh_ld,
  input  logic                   ser,
  input  logic [LS166_WIDTH-1:0] d,
  output logic                   qh
`ifdef LS166_TAP_EN
  ,
  output logic [LS166_WIDTH-1:0] q
`endif
);

  ls166_word_t s;
  ls166_word_t up;

  // Stage A takes ser; every other stage takes its upstream neighbour.
  assign up = {ser, s[LS166_WIDTH-1:1]};

  for (genvar i = 0; i < LS166_WIDTH; i++) begin : g_stage
    ls166_cell u_cell (
      .clk   (clk),
      ._clr  (_clr),
      .hold  (clk_inh),
      .sh_ld (sh_ld),
      .par   (d[i]),
      .up    (up[i]),
      .q     (s[i])
    );
  end

  assign qh = s[0];

`ifdef LS166_TAP_EN
  assign q = s;
`endif

endmodule
